// File: rtl/uart_tx_param.sv
// uart_tx_param: single-clock UART transmitter with byte FIFO and fixed frame format.
// Optional line-break support is enabled by defining UART_TX_BREAK_EN.
module uart_tx_param #(
    parameter int unsigned CLK_HZ     = 20000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        i_clk_20mhz,
    input  logic                        i_rst_20mhz,
    input  logic [7:0]                  i_tx_data,
    input  logic                        i_tx_valid,
`ifdef UART_TX_BREAK_EN
    input  logic                        i_break,
`endif
    output logic                        o_tx_ready,
    output logic                        o_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
    output logic                        eo_uart_tx
);
    localparam int unsigned DIV        = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned FRAME_BITS = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
    localparam int unsigned FRAME_LEN  = FRAME_BITS * DIV;
    localparam int unsigned CNT_W      = $clog2(FRAME_LEN + 1);
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned FC_W       = PTR_W + 1;
    localparam int unsigned IDX_W      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_BITS * DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [FC_W-1:0]  DEPTH_C  = FC_W'(FIFO_DEPTH);
`ifdef UART_TX_BREAK_EN
    localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_LEN - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
`ifdef UART_TX_BREAK_EN
        , ST_BREAK
`endif
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 line_q, line_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [FC_W-1:0]      count_q, count_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
`ifdef UART_TX_BREAK_EN
    logic                 brk_rel_q, brk_rel_d;
`endif

    logic wr_en;
    logic pop;
    logic fifo_ne;
    logic parity_bit;

    always_comb begin
        o_tx_ready   = (count_q < DEPTH_C);
        o_tx_busy    = (state_q != ST_IDLE) || (count_q != '0);
        o_fifo_count = count_q;
        eo_uart_tx   = line_q;
        wr_en        = i_tx_valid && o_tx_ready;
        fifo_ne      = (count_q != '0);
        parity_bit   = (PARITY == 1) ? ~(^shift_q) : (^shift_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        line_d  = 1'b1;
        pop     = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk_rel_d = brk_rel_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
`ifdef UART_TX_BREAK_EN
                if (i_break) begin
                    state_d   = ST_BREAK;
                    brk_rel_d = 1'b0;
                end else
`endif
                if (fifo_ne) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                line_d = 1'b0;
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                line_d = shift_q[idx_q];
                if (cnt_q == BIT_END) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                line_d = parity_bit;
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == STOP_END) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
`ifdef UART_TX_BREAK_EN
                    if (i_break) begin
                        state_d   = ST_BREAK;
                        brk_rel_d = 1'b0;
                    end else
`endif
                    if (fifo_ne) begin
                        pop     = 1'b1;
                        state_d = ST_START;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            // Low phase saturates at one frame length so a short request still yields a full break.
            ST_BREAK: begin
                line_d = brk_rel_q;
                if (!brk_rel_q) begin
                    if (cnt_q == FRAME_END) begin
                        cnt_d = cnt_q;
                        if (!i_break) begin
                            brk_rel_d = 1'b1;
                            cnt_d     = '0;
                        end
                    end
                end else if (cnt_q == BIT_END) begin
                    cnt_d     = '0;
                    brk_rel_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
`endif
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        if (pop) begin
            shift_d = mem_q[rd_ptr_q];
            idx_d   = '0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + FC_W'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - FC_W'(1);
        end
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            line_q   <= 1'b1;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
`ifdef UART_TX_BREAK_EN
            brk_rel_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            line_q   <= line_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
`ifdef UART_TX_BREAK_EN
            brk_rel_q <= brk_rel_d;
`endif
        end
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= i_tx_data[DATA_BITS-1:0];
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: three configurations (8N1, 8E1, 7O2) decoded by one line monitor.
module tb_uart_tx_param;
    localparam int DIV = 174;

    logic clk = 1'b0;
    always #25 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_a, valid_a, ready_a, busy_a, line_a;
    logic [7:0] data_a;
    logic [4:0] cnt_a;
    logic       rst_bc, valid_b, ready_b, busy_b, line_b;
    logic [7:0] data_b;
    logic [4:0] cnt_b;
    logic       valid_c, ready_c, busy_c, line_c;
    logic [7:0] data_c;
    logic [4:0] cnt_c;
`ifdef UART_TX_BREAK_EN
    logic       brk, brk_off;
`endif

    uart_tx_param u_a (
        .i_clk_20mhz (clk),
        .i_rst_20mhz (rst_a),
        .i_tx_data   (data_a),
        .i_tx_valid  (valid_a),
`ifdef UART_TX_BREAK_EN
        .i_break     (brk),
`endif
        .o_tx_ready  (ready_a),
        .o_tx_busy   (busy_a),
        .o_fifo_count(cnt_a),
        .eo_uart_tx  (line_a)
    );

    uart_tx_param #(.PARITY(2)) u_b (
        .i_clk_20mhz (clk),
        .i_rst_20mhz (rst_bc),
        .i_tx_data   (data_b),
        .i_tx_valid  (valid_b),
`ifdef UART_TX_BREAK_EN
        .i_break     (brk_off),
`endif
        .o_tx_ready  (ready_b),
        .o_tx_busy   (busy_b),
        .o_fifo_count(cnt_b),
        .eo_uart_tx  (line_b)
    );

    uart_tx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
        .i_clk_20mhz (clk),
        .i_rst_20mhz (rst_bc),
        .i_tx_data   (data_c),
        .i_tx_valid  (valid_c),
`ifdef UART_TX_BREAK_EN
        .i_break     (brk_off),
`endif
        .o_tx_ready  (ready_c),
        .o_tx_busy   (busy_c),
        .o_fifo_count(cnt_c),
        .eo_uart_tx  (line_c)
    );

    int checks = 0;
    int passes = 0;

    // Expected frames, slot i of the vector is the line level during bit time i (slot 0 = start).
    logic [11:0] exp_q0[$];
    logic [11:0] exp_q1[$];
    logic [11:0] exp_q2[$];
    int          start0_q[$];

    int          flen[3] = '{10 * DIV, 11 * DIV, 11 * DIV};
    logic        mon_en[3] = '{1'b0, 1'b0, 1'b0};
    logic        active[3] = '{1'b0, 1'b0, 1'b0};
    logic        bad[3];
    logic        unexp[3];
    logic [11:0] cur[3];
    logic [11:0] got[3];
    int          pos[3];
    int          done[3] = '{0, 0, 0};
    int          last_start[3] = '{0, 0, 0};
    int          gap[3] = '{0, 0, 0};
    logic [2:0]  lines;
    int          bit_n;
    logic        bc_done = 1'b0;

    function automatic logic [11:0] f8n1(input logic [7:0] b);
        return {2'b00, 1'b1, b, 1'b0};
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act == exp_v) passes++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp_v);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act >= lo && act <= hi) passes++;
        else $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    endtask

    task automatic wait_done(input int g, input int target, input int limit, input string name);
        int k = 0;
        while (done[g] < target && k < limit) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (done[g] >= target) passes++;
        else $display("FAIL %s: %0d frames on ch%0d, required %0d", name, done[g], g, target);
    endtask

    // Monitor: every line cycle of a frame must match the expected slot level exactly.
    always @(negedge clk) begin
        lines = {line_c, line_b, line_a};
        for (int g = 0; g < 3; g++) begin
            if (mon_en[g] && !active[g] && !lines[g]) begin
                active[g] = 1'b1;
                pos[g]    = 0;
                bad[g]    = 1'b0;
                unexp[g]  = 1'b0;
                got[g]    = '0;
                cur[g]    = '0;
                gap[g]    = cyc - last_start[g];
                last_start[g] = cyc;
                if (g == 0) start0_q.push_back(cyc);
                case (g)
                    0: if (exp_q0.size() != 0) cur[g] = exp_q0.pop_front(); else unexp[g] = 1'b1;
                    1: if (exp_q1.size() != 0) cur[g] = exp_q1.pop_front(); else unexp[g] = 1'b1;
                    default: if (exp_q2.size() != 0) cur[g] = exp_q2.pop_front(); else unexp[g] = 1'b1;
                endcase
            end
            if (active[g]) begin
                bit_n = pos[g] / DIV;
                if (lines[g] != cur[g][bit_n]) bad[g] = 1'b1;
                if (pos[g] % DIV == DIV / 2) got[g][bit_n] = lines[g];
                pos[g]++;
                if (pos[g] == flen[g]) begin
                    active[g] = 1'b0;
                    done[g]++;
                    checks++;
                    if (!bad[g] && !unexp[g]) passes++;
                    else $display("FAIL frame_ch%0d: line %b, required %b%s", g, got[g], cur[g],
                                  unexp[g] ? " (no frame expected)" : "");
                end
            end
        end
    end

    initial begin
        #(50 * 95000);
        $display("FAIL watchdog: cycle budget exceeded, %0d/%0d checks so far", passes, checks);
        $fatal(1, "watchdog");
    end

    // Channel A: 8N1 latency, FIFO fill, optional break, reset mid-frame.
    initial begin
        int n0, k, lo, hi, bad_gaps;
        rst_a = 1'b1; valid_a = 1'b0; data_a = '0;
`ifdef UART_TX_BREAK_EN
        brk = 1'b0; brk_off = 1'b0;
`endif
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_line", line_a, 1);
        check("rst_count", cnt_a, 0);
        check("rst_ready", ready_a, 1);
        check("rst_busy", busy_a, 0);
        rst_a = 1'b0;
        mon_en[0] = 1'b1;

        @(negedge clk);
        exp_q0.push_back(f8n1(8'h55));
        data_a = 8'h55; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0; n0 = cyc;
        check("lat_n_count", cnt_a, 1);
        check("lat_n_busy", busy_a, 1);
        check("lat_n_line", line_a, 1);
        @(negedge clk);
        check("lat_n1_count", cnt_a, 0);
        check("lat_n1_line", line_a, 1);
        @(negedge clk);
        check("lat_n2_line", line_a, 0);
        k = 0;
        while (busy_a && k < 5000) begin @(negedge clk); k++; end
        check("busy_fall_cycle", cyc - n0, 1741);
        wait_done(0, 1, 100, "frame_55");

        start0_q.delete();
        repeat (10) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            data_a = 8'(i); valid_a = 1'b1;
            exp_q0.push_back(f8n1(8'(i)));
            @(negedge clk);
        end
        check("full_count", cnt_a, 16);
        check("full_ready", ready_a, 0);
        data_a = 8'h77;
        @(negedge clk);
        valid_a = 1'b0;
        check("full_write_ignored", cnt_a, 16);
        wait_done(0, 18, 17 * 1740 + 2000, "fifo_frames");
        check("b2b_starts", start0_q.size(), 17);
        bad_gaps = 0;
        for (int i = 1; i < start0_q.size(); i++)
            if (start0_q[i] - start0_q[i-1] != 1740) bad_gaps++;
        check("b2b_bad_gaps", bad_gaps, 0);
        repeat (2) @(negedge clk);
        check("fifo_drained_busy", busy_a, 0);
        check("fifo_drained_count", cnt_a, 0);

`ifdef UART_TX_BREAK_EN
        @(negedge clk);
        exp_q0.push_back(f8n1(8'hA5));
        data_a = 8'hA5; valid_a = 1'b1;
        @(negedge clk);
        data_a = 8'h3C;
        @(negedge clk);
        valid_a = 1'b0; brk = 1'b1;
        wait_done(0, 19, 3000, "frame_a5");
        mon_en[0] = 1'b0;
        check("break_holds_fifo", cnt_a, 1);
        k = 0;
        while (line_a && k < 100) begin @(negedge clk); k++; end
        lo = 0;
        while (!line_a && lo < 5000) begin
            if (lo == 300) brk = 1'b0;
            @(negedge clk);
            lo++;
        end
        check_range("break_low_len", lo, 1740, 1741);
        exp_q0.push_back(f8n1(8'h3C));
        mon_en[0] = 1'b1;
        hi = 0;
        while (line_a && hi < 5000) begin @(negedge clk); hi++; end
        check_range("break_release_high", hi, DIV, DIV + 1);
        wait_done(0, 20, 3000, "frame_3c");
`endif

        mon_en[0] = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            data_a = 8'h11 * 8'(i + 1); valid_a = 1'b1;
            @(negedge clk);
        end
        valid_a = 1'b0;
        k = 0;
        while (line_a && k < 100) begin @(negedge clk); k++; end
        repeat (500) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        check("midrst_line", line_a, 1);
        check("midrst_count", cnt_a, 0);
        check("midrst_busy", busy_a, 0);
        rst_a = 1'b0;
        lo = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!line_a) lo++;
        end
        check("midrst_no_tx_low_cycles", lo, 0);

        k = 0;
        while (!bc_done && k < 20000) begin @(negedge clk); k++; end
        check("bc_finished", bc_done, 1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Channels B (8E1) and C (7O2): parity values, ignored bit 7, exact frame spacing.
    initial begin
        rst_bc = 1'b1; valid_b = 1'b0; valid_c = 1'b0; data_b = '0; data_c = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_b_ready", ready_b, 1);
        check("rst_c_busy", busy_c, 0);
        rst_bc = 1'b0;
        mon_en[1] = 1'b1;
        mon_en[2] = 1'b1;

        @(negedge clk);
        exp_q1.push_back({1'b0, 1'b1, 1'b0, 8'h03, 1'b0});
        exp_q1.push_back({1'b0, 1'b1, 1'b1, 8'h07, 1'b0});
        exp_q2.push_back({1'b0, 2'b11, 1'b0, 7'h7F, 1'b0});
        exp_q2.push_back({1'b0, 2'b11, 1'b1, 7'h03, 1'b0});
        data_b = 8'h03; valid_b = 1'b1;
        data_c = 8'hFF; valid_c = 1'b1;
        @(negedge clk);
        data_b = 8'h07; data_c = 8'h03;
        @(negedge clk);
        valid_b = 1'b0; valid_c = 1'b0;
        wait_done(1, 2, 2 * 1914 + 500, "frames_b");
        check("b_frame_spacing", gap[1], 1914);
        wait_done(2, 2, 1000, "frames_c");
        check("c_frame_spacing", gap[2], 1914);

        @(negedge clk);
        exp_q2.push_back({1'b0, 2'b11, 1'b1, 7'h00, 1'b0});
        data_c = 8'h80; valid_c = 1'b1;
        @(negedge clk);
        valid_c = 1'b0;
        wait_done(2, 3, 2500, "frame_c_80");
        bc_done = 1'b1;
    end

endmodule
